// File: rtl/sram_sync_2p_if.sv
// Port bundle for sram_sync_2p: write port, registered read port, clear request and sweep status.
// The master side drives accesses and the slave side is the memory.
interface sram_sync_2p_if #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic              clear;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;
    logic              rd_valid;
    logic              init_busy;

    modport master (
        output clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, init_busy
    );

    modport slave (
        input  clear, wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, init_busy
    );
endinterface

// File: rtl/sram_sync_2p.sv
// Simple-dual-port synchronous SRAM: one write port and one registered read port.
// A clear sequencer zeroes every word after reset or on a clear request.
module sram_sync_2p #(
    parameter int DEPTH  = 128,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset_n,
    sram_sync_2p_if.slave  bus
);
    localparam logic [0:0]        ST_INIT   = 1'b0;
    localparam logic [0:0]        ST_RUN    = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    // The array is deliberately outside reset; the sweep gives it defined contents.
    logic [WIDTH-1:0]  r_mem [0:DEPTH-1];
    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_init_ptr;
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;

    logic              w_run;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [WIDTH-1:0]  w_mem_wdata;
    logic [WIDTH-1:0]  w_rd_word;

    // A clear request pre-empts both ports in the cycle it is seen.
    assign w_run         = (r_state == ST_RUN);
    assign w_wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_EXT);
    assign w_rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_EXT);
    assign w_wr_accept   = w_run & ~bus.clear & bus.wr_en & w_wr_in_range;
    assign w_rd_accept   = w_run & ~bus.clear & bus.rd_en;

    // Array write port: the sweep owns it in INIT, the user write port in RUN.
    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = r_init_ptr;
        w_mem_wdata = '0;
        if (!w_run) begin
            w_mem_we = 1'b1;
        end else if (w_wr_accept) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = bus.wr_addr;
            w_mem_wdata = bus.wr_data;
        end else begin
            w_mem_we = 1'b0;
        end
    end

    // Read word with write-first bypass; out-of-range addresses read as zero.
    always_comb begin
        w_rd_word = '0;
        if (!w_rd_in_range) begin
            w_rd_word = '0;
        end else if (w_wr_accept && (bus.wr_addr == bus.rd_addr)) begin
            w_rd_word = bus.wr_data;
        end else begin
            w_rd_word = r_mem[bus.rd_addr];
        end
    end

    // Storage array write.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // Sweep sequencer: INIT walks every address once, RUN serves accesses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_ptr == LAST_ADDR) begin
                        r_state    <= ST_RUN;
                        r_init_ptr <= '0;
                    end else begin
                        r_init_ptr <= r_init_ptr + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.clear) begin
                        r_state    <= ST_INIT;
                        r_init_ptr <= '0;
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_ptr <= '0;
                end
            endcase
        end
    end

    // Registered read port: data holds when no read is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_accept) begin
            r_rd_data  <= w_rd_word;
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.init_busy = (r_state == ST_INIT);
endmodule

// File: tb/tb_sram_sync_2p.sv
// Bench for sram_sync_2p: a 128x8 and a 100x16 instance checked every cycle against an
// array-level model, plus directed reads with literal expected values.
module tb_sram_sync_2p;
    localparam int DEP_A = 128;
    localparam int WID_A = 8;
    localparam int DEP_B = 100;
    localparam int WID_B = 16;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    sram_sync_2p_if #(.DEPTH(DEP_A), .WIDTH(WID_A)) bus_a ();
    sram_sync_2p_if #(.DEPTH(DEP_B), .WIDTH(WID_B)) bus_b ();

    sram_sync_2p #(.DEPTH(DEP_A), .WIDTH(WID_A)) u_dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
    sram_sync_2p #(.DEPTH(DEP_B), .WIDTH(WID_B)) u_dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

    int   n_total = 0;
    int   n_pass  = 0;
    logic cmp_on  = 1'b0;

    // Uniform views of both instances, indexed 0 (A) and 1 (B).
    logic        m_clr [2];
    logic        m_we  [2];
    logic        m_re  [2];
    int          m_wa  [2];
    int          m_ra  [2];
    logic [15:0] m_wd  [2];
    logic [15:0] d_data [2];
    logic        d_valid[2];
    logic        d_busy [2];

    assign m_clr[0] = bus_a.clear;  assign m_clr[1] = bus_b.clear;
    assign m_we[0]  = bus_a.wr_en;  assign m_we[1]  = bus_b.wr_en;
    assign m_re[0]  = bus_a.rd_en;  assign m_re[1]  = bus_b.rd_en;
    assign m_wa[0]  = int'(bus_a.wr_addr); assign m_wa[1] = int'(bus_b.wr_addr);
    assign m_ra[0]  = int'(bus_a.rd_addr); assign m_ra[1] = int'(bus_b.rd_addr);
    assign m_wd[0]  = {8'h00, bus_a.wr_data}; assign m_wd[1] = bus_b.wr_data;
    assign d_data[0]  = {8'h00, bus_a.rd_data}; assign d_data[1] = bus_b.rd_data;
    assign d_valid[0] = bus_a.rd_valid; assign d_valid[1] = bus_b.rd_valid;
    assign d_busy[0]  = bus_a.init_busy; assign d_busy[1] = bus_b.init_busy;

    function automatic int dep(input int k);
        return (k == 0) ? DEP_A : DEP_B;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s inst=%0d t=%0t: got %0h expected %0h", name, k, $time, act, exp);
        end
    endtask

    // Model: the array is zeroed as a whole when a sweep starts; busy_left counts remaining sweep edges.
    logic [15:0] mdl_mem [2][128];
    int          busy_left [2];
    logic [15:0] exp_data  [2];
    logic        exp_valid [2];

    always @(posedge clk or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                busy_left[k] <= dep(k);
                exp_data[k]  <= 16'h0000;
                exp_valid[k] <= 1'b0;
                for (int i = 0; i < 128; i++) mdl_mem[k][i] <= 16'h0000;
            end else if (busy_left[k] > 0) begin
                busy_left[k] <= busy_left[k] - 1;
                exp_valid[k] <= 1'b0;
            end else if (m_clr[k]) begin
                busy_left[k] <= dep(k);
                exp_valid[k] <= 1'b0;
                for (int i = 0; i < 128; i++) mdl_mem[k][i] <= 16'h0000;
            end else begin
                if (m_we[k] && m_wa[k] < dep(k)) mdl_mem[k][m_wa[k]] <= m_wd[k];
                if (m_re[k]) begin
                    exp_valid[k] <= 1'b1;
                    if (m_ra[k] >= dep(k))                    exp_data[k] <= 16'h0000;
                    else if (m_we[k] && m_wa[k] == m_ra[k])   exp_data[k] <= m_wd[k];
                    else                                      exp_data[k] <= mdl_mem[k][m_ra[k]];
                end else begin
                    exp_valid[k] <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            for (int k = 0; k < 2; k++) begin
                check("cyc_busy",  k, {31'd0, d_busy[k]},  {31'd0, (busy_left[k] != 0)});
                check("cyc_valid", k, {31'd0, d_valid[k]}, {31'd0, exp_valid[k]});
                check("cyc_data",  k, {16'd0, d_data[k]},  {16'd0, exp_data[k]});
            end
        end
    end

    task automatic drive(input int k, input logic clr, input logic we, input int wa,
                         input logic [15:0] wd, input logic re, input int ra);
        if (k == 0) begin
            bus_a.clear = clr; bus_a.wr_en = we; bus_a.wr_addr = wa[6:0]; bus_a.wr_data = wd[7:0];
            bus_a.rd_en = re;  bus_a.rd_addr = ra[6:0];
        end else begin
            bus_b.clear = clr; bus_b.wr_en = we; bus_b.wr_addr = wa[6:0]; bus_b.wr_data = wd;
            bus_b.rd_en = re;  bus_b.rd_addr = ra[6:0];
        end
    endtask

    // Apply one cycle of inputs and return just after the edge that samples them.
    task automatic step(input int k, input logic clr, input logic we, input int wa,
                        input logic [15:0] wd, input logic re, input int ra);
        @(negedge clk);
        drive(k, clr, we, wa, wd, re, ra);
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input int k, input int addr, input logic [15:0] exp, input string name);
        step(k, 1'b0, 1'b0, 0, 16'h0, 1'b1, addr);
        check(name, k, {16'd0, d_data[k]}, {16'd0, exp});
        check({name, "_v"}, k, {31'd0, d_valid[k]}, 32'd1);
    endtask

    task automatic wait_idle(input int k, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (d_busy[k] && cnt < 400);
    endtask

    initial begin
        int ca;
        int cb;
        int e;
        int cnt;
        drive(0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);
        drive(1, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp_on = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_data",  k, {16'd0, d_data[k]}, 32'd0);
            check("rst_valid", k, {31'd0, d_valid[k]}, 32'd0);
            check("rst_busy",  k, {31'd0, d_busy[k]}, 32'd1);
        end

        // Sweep length after reset release.
        @(negedge clk);
        reset_n = 1'b1;
        ca = 0; cb = 0; e = 0;
        while ((d_busy[0] || d_busy[1]) && e < 400) begin
            @(posedge clk);
            #1;
            e++;
            if (!d_busy[0] && ca == 0) ca = e;
            if (!d_busy[1] && cb == 0) cb = e;
        end
        check("busy_len", 0, ca, 32'd128);
        check("busy_len", 1, cb, 32'd100);

        for (int i = 0; i < DEP_A; i++) rd_chk(0, i, 16'h0000, "sweep_rd");
        step(0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);
        check("valid_drop", 0, {31'd0, d_valid[0]}, 32'd0);

        // Write then read, and an untouched neighbour.
        step(0, 1'b0, 1'b1, 5, 16'h00A5, 1'b0, 0);
        rd_chk(0, 5, 16'h00A5, "wr_rd");
        rd_chk(0, 6, 16'h0000, "rd_neigh");

        // Same-cycle read and write: new data is returned.
        step(0, 1'b0, 1'b1, 10, 16'h00FF, 1'b0, 0);
        step(0, 1'b0, 1'b1, 10, 16'h003C, 1'b1, 10);
        check("bypass",   0, {16'd0, d_data[0]}, 32'h3C);
        check("bypass_v", 0, {31'd0, d_valid[0]}, 32'd1);
        step(0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);
        check("hold", 0, {16'd0, d_data[0]}, 32'h3C);
        rd_chk(0, 10, 16'h003C, "after_bypass");

        // Clear with a concurrent write and read, then accesses during the sweep.
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, i, 16'((i + 1) * 17), 1'b0, 0);
        rd_chk(0, 2, 16'h0033, "fill");
        step(0, 1'b1, 1'b1, 2, 16'h0099, 1'b1, 1);
        check("clr_rd_drop", 0, {31'd0, d_valid[0]}, 32'd0);
        check("clr_busy",    0, {31'd0, d_busy[0]}, 32'd1);
        @(negedge clk);
        drive(0, 1'b0, 1'b1, 3, 16'h0077, 1'b1, 0);
        wait_idle(0, cnt);
        check("clr_busy_len", 0, cnt, 32'd128);
        for (int i = 0; i < 4; i++) rd_chk(0, i, 16'h0000, "clr_rd");
        rd_chk(0, 5, 16'h0000, "clr_rd5");

        // Non-power-of-two depth: out-of-range write dropped, out-of-range read is zero.
        step(1, 1'b0, 1'b1, 20, 16'h5555, 1'b0, 0);
        step(1, 1'b0, 1'b1, 99, 16'hBEEF, 1'b0, 0);
        step(1, 1'b0, 1'b1, 120, 16'h1234, 1'b0, 0);
        rd_chk(1, 99, 16'hBEEF, "np2_99");
        rd_chk(1, 120, 16'h0000, "np2_120");
        rd_chk(1, 20, 16'h5555, "np2_20");
        step(1, 1'b0, 1'b1, 120, 16'hABCD, 1'b1, 120);
        check("oor_collide",   1, {16'd0, d_data[1]}, 32'd0);
        check("oor_collide_v", 1, {31'd0, d_valid[1]}, 32'd1);
        rd_chk(1, 127, 16'h0000, "np2_127");
        for (int i = 0; i < DEP_B; i++) step(1, 1'b0, 1'b0, 0, 16'h0, 1'b1, i);
        step(1, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);

        // Reset in the middle of a clear sweep.
        step(0, 1'b0, 1'b1, 7, 16'h005A, 1'b0, 0);
        rd_chk(0, 7, 16'h005A, "pre_rst");
        step(0, 1'b1, 1'b0, 0, 16'h0, 1'b0, 0);
        check("init_hold", 0, {16'd0, d_data[0]}, 32'h5A);
        step(0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);
        repeat (38) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_data",  0, {16'd0, d_data[0]}, 32'd0);
        check("async_valid", 0, {31'd0, d_valid[0]}, 32'd0);
        check("async_busy",  0, {31'd0, d_busy[0]}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_idle(0, cnt);
        check("rst_busy_len", 0, cnt, 32'd128);
        rd_chk(0, 7, 16'h0000, "post_rst");
        rd_chk(1, 99, 16'h0000, "post_rst");
        step(0, 1'b0, 1'b0, 0, 16'h0, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
